// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the multiplexed 7-segment scanner.
package seg_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = SEG_W'(0);

    typedef logic [BCD_W-1:0] bcd_t;

    // The external decoder expects weight 8 on bit 0 and weight 1 on bit 3.
    function automatic bcd_t bcd_rev(input bcd_t n);
        return {n[0], n[1], n[2], n[3]};
    endfunction

    function automatic logic bcd_valid(input bcd_t n);
        return (n <= 4'd9);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: loadable down-counter with terminal-count flags, shared by BLANK and DRIVE timing.
module seg_scan_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc_c,
    output logic             tc_nxt_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on request, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c     = (cnt_q == '0);
    assign tc_nxt_c = (cnt_d == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed BCD display scanner driving an external 7-segment decoder.
// Optional macro LZ_BLANK_EN enables leading-zero suppression (digit 0 is never suppressed).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   value,
    output logic [BCD_W-1:0]              dec_num,
    input  logic [SEG_W-1:0]              seg_in,
    output logic [SEG_W-1:0]              seg_out,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic                          frame_done
);

    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned VAL_W   = BCD_W * NUM_DIGITS;
    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc_c;
    logic             tmr_tc_nxt_c;

    logic [VAL_W-1:0] pending_q;
    logic [VAL_W-1:0] display_q, display_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] digits_d;
    logic [NUM_DIGITS-1:0] lz_mask;
    bcd_t             cur_digit;
    logic             wrap_c;

    logic [NUM_DIGITS-1:0] an_n_d;
    logic [SEG_W-1:0]      seg_out_d;
    bcd_t                  dec_num_d;
    logic                  frame_done_d;
    logic                  force_blank_q, force_blank_d;

    seg_scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc_c     (tmr_tc_c),
        .tc_nxt_c (tmr_tc_nxt_c)
    );

    // State, digit index and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            an_n          <= '1;
            seg_out       <= SEG_BLANK;
            dec_num       <= '0;
            frame_done    <= 1'b0;
            force_blank_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            an_n          <= an_n_d;
            seg_out       <= seg_out_d;
            dec_num       <= dec_num_d;
            frame_done    <= frame_done_d;
            force_blank_q <= force_blank_d;
        end
    end

    // Next state and index; the timer reloads on every state entry so frames never drift.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                end
                ST_BLANK: begin
                    if (tmr_tc_c) state_d = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (tmr_tc_c) begin
                        state_d = ST_BLANK;
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
        if (state_d != state_q) begin
            tmr_load = 1'b1;
            case (state_d)
                ST_BLANK: tmr_val = BLANK_LD;
                ST_DRIVE: tmr_val = DWELL_LD;
                default:  tmr_val = '0;
            endcase
        end
    end

    assign wrap_c = (state_q == ST_DRIVE) && tmr_tc_c && (idx_q == LAST_IDX);

    // Display follows pending while idle and at each frame wrap; a same-cycle load wins.
    always_comb begin
        display_d = display_q;
        if ((state_q == ST_IDLE) || wrap_c) begin
            display_d = load ? value : pending_q;
        end
    end

    // Pending capture and tear-free display register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            display_q <= '0;
        end else begin
            if (load) pending_q <= value;
            display_q <= display_d;
        end
    end

    assign digits_d  = display_d;
    assign cur_digit = digits_d[idx_d];

`ifdef LZ_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero && (digits_d[k] == '0);
            lz_mask[k] = all_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Output next-values; seg_out blanks the digit whose nibble the decoder is currently seeing.
    always_comb begin
        an_n_d        = '1;
        dec_num_d     = '0;
        frame_done_d  = 1'b0;
        force_blank_d = 1'b1;
        seg_out_d     = force_blank_q ? SEG_BLANK : seg_in;
        if (state_d == ST_IDLE) begin
            seg_out_d = SEG_BLANK;
        end else begin
            dec_num_d     = bcd_rev(cur_digit);
            force_blank_d = !bcd_valid(cur_digit) || lz_mask[idx_d];
            if (state_d == ST_DRIVE) begin
                an_n_d[idx_d] = 1'b0;
                frame_done_d  = (idx_d == LAST_IDX) && tmr_tc_nxt_c;
            end
        end
    end

endmodule
